// File: rtl/usb_nint_sequencer_if.sv
// Bus bundle for usb_nint_sequencer.
//   CPU side (Avalon-MM slave):  address, chipselect, read_n, write_n, writedata, readdata
//   HPI side (Avalon-MM master): m_address, m_read_n, m_write_n, m_writedata,
//                                m_readdata, m_waitrequest
// Modport master: the sequencer's view. It answers CPU accesses and drives the HPI strobes.
// Modport slave:  the environment's view. This is the CPU, the HPI bridge or a testbench.
interface usb_nint_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_read_n;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  address, chipselect, read_n, write_n, writedata, m_readdata, m_waitrequest,
    output readdata, m_address, m_read_n, m_write_n, m_writedata
  );

  modport slave (
    output address, chipselect, read_n, write_n, writedata, m_readdata, m_waitrequest,
    input  readdata, m_address, m_read_n, m_write_n, m_writedata
  );
endinterface

// File: rtl/usb_nint_sequencer.sv
// Services the USB controller's active-low nINT line without CPU polling.
// On an assertion, the block reads the controller status register over HPI. It then writes the
// value back as a write-1-to-clear ack, latches it, and raises irq. irq stays high until the CPU
// clears pending.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   nint   asynchronous active-low interrupt from the USB controller
//   bus    CPU slave registers and HPI master strobes (usb_nint_sequencer_if.master)
//   irq    registered interrupt to the CPU, pending & irq_mask
// Register map: 0 STATUS (RO), 1 CAPTURE (RO), 2 MASK (RW), 3 CLEAR (WO, reads 0)
module usb_nint_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  STATUS_ADDR = 2'd2,
  parameter bit          ACK_WRITE   = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   nint,
  usb_nint_sequencer_if.master   bus,
  output logic                   irq
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StPost} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  // The chain holds the inverted line, so an all-zero reset value means "not asserted".
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   nint_s, nint_s_prev_q;
  logic [1:0]             m_address_q, m_address_d;
  logic                   m_read_n_q, m_read_n_d, m_write_n_q, m_write_n_d;
  logic [15:0]            m_writedata_q, m_writedata_d, capture_q, capture_d;
  logic [7:0]             tmo_cnt_q, tmo_cnt_d;
  logic                   pending_q, pending_d, overrun_q, overrun_d;
  logic                   tmo_err_q, tmo_err_d, mask_q, mask_d, irq_q;
  logic [31:0]            readdata_q, readdata_d;
  logic                   set_pending, set_tmo, ovr_evt, busy, wr_en, rd_en;
  logic [2:0]             clr;
  logic                   unused_wdata;

  assign nint_s  = sync_q[SYNC_STAGES-1];
  assign busy    = (state_q != StIdle);
  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign rd_en   = bus.chipselect & ~bus.read_n;
  assign clr     = (wr_en && bus.address == 2'd3) ? bus.writedata[2:0] : 3'b000;
  assign ovr_evt = nint_s & ~nint_s_prev_q & (pending_q | busy);
  assign unused_wdata = ^bus.writedata[31:3];

  // FSM next-state and registered master strobes
  always_comb begin
    state_d       = state_q;
    m_address_d   = m_address_q;
    m_read_n_d    = m_read_n_q;
    m_write_n_d   = m_write_n_q;
    m_writedata_d = m_writedata_q;
    capture_d     = capture_q;
    tmo_cnt_d     = tmo_cnt_q;
    set_pending   = 1'b0;
    set_tmo       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nint_s && !pending_q) begin
          state_d     = StRd;
          m_address_d = STATUS_ADDR;
          m_read_n_d  = 1'b0;
          tmo_cnt_d   = 8'd0;
        end
      end
      StRd: begin
        if (!bus.m_waitrequest) begin
          capture_d  = bus.m_readdata;
          m_read_n_d = 1'b1;
          tmo_cnt_d  = 8'd0;
          if (ACK_WRITE) begin
            state_d       = StWr;
            m_writedata_d = bus.m_readdata;
            m_write_n_d   = 1'b0;
          end else begin
            state_d = StPost;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          m_read_n_d = 1'b1;
          set_tmo    = 1'b1;
          state_d    = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StWr: begin
        if (!bus.m_waitrequest) begin
          m_write_n_d = 1'b1;
          tmo_cnt_d   = 8'd0;
          state_d     = StPost;
        end else if (tmo_cnt_q == TmoLast) begin
          m_write_n_d = 1'b1;
          set_tmo     = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StPost: begin
        set_pending = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Flags: a set in the same cycle as a CPU clear wins
  always_comb begin
    pending_d = set_pending | (pending_q & ~clr[0]);
    overrun_d = ovr_evt     | (overrun_q & ~clr[1]);
    tmo_err_d = set_tmo     | (tmo_err_q & ~clr[2]);
    mask_d    = (wr_en && bus.address == 2'd2) ? bus.writedata[0] : mask_q;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (bus.address)
        2'd0: readdata_d = {27'd0, tmo_err_q, overrun_q, busy, pending_q, nint_s};
        2'd1: readdata_d = {16'd0, capture_q};
        2'd2: readdata_d = {31'd0, mask_q};
        2'd3: readdata_d = 32'd0;
        default: readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      sync_q        <= '0;
      nint_s_prev_q <= 1'b0;
      m_address_q   <= 2'd0;
      m_read_n_q    <= 1'b1;
      m_write_n_q   <= 1'b1;
      m_writedata_q <= 16'd0;
      capture_q     <= 16'd0;
      tmo_cnt_q     <= 8'd0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
      mask_q        <= 1'b0;
      irq_q         <= 1'b0;
      readdata_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], ~nint};
      nint_s_prev_q <= nint_s;
      m_address_q   <= m_address_d;
      m_read_n_q    <= m_read_n_d;
      m_write_n_q   <= m_write_n_d;
      m_writedata_q <= m_writedata_d;
      capture_q     <= capture_d;
      tmo_cnt_q     <= tmo_cnt_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      tmo_err_q     <= tmo_err_d;
      mask_q        <= mask_d;
      irq_q         <= pending_q & mask_q;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.m_address   = m_address_q;
  assign bus.m_read_n    = m_read_n_q;
  assign bus.m_write_n   = m_write_n_q;
  assign bus.m_writedata = m_writedata_q;
  assign bus.readdata    = readdata_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_usb_nint_sequencer.sv
// Directed bench for usb_nint_sequencer with SYNC_STAGES=2, STATUS_ADDR=2, ACK_WRITE=1 and
// TIMEOUT=255. Inputs are driven, and outputs sampled, 1 ns after each rising edge.
module tb_usb_nint_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic nint;
  logic irq;
  int   errors = 0;
  int   checks = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [1:0]  last_rd_addr = 2'd0;
  logic [15:0] last_wr_data = 16'd0;
  int   rd_base, wr_base;
  logic [31:0] rdata;

  usb_nint_sequencer_if bus ();

  usb_nint_sequencer #(
    .SYNC_STAGES (2),
    .STATUS_ADDR (2'd2),
    .ACK_WRITE   (1'b1),
    .TIMEOUT     (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .nint  (nint),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Completed HPI transfers, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.m_read_n && !bus.m_waitrequest) begin
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= bus.m_address;
      end
      if (!bus.m_write_n && !bus.m_waitrequest) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_data <= bus.m_writedata;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.address    = a;
    tick();
    d = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  initial begin
    reset             = 1'b1;
    nint              = 1'b1;
    bus.chipselect    = 1'b0;
    bus.read_n        = 1'b1;
    bus.write_n       = 1'b1;
    bus.address       = 2'd0;
    bus.writedata     = 32'd0;
    bus.m_readdata    = 16'h0012;
    bus.m_waitrequest = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_m_read_n", {31'd0, bus.m_read_n}, 32'd1);
    check("rst_m_write_n", {31'd0, bus.m_write_n}, 32'd1);
    check("rst_m_address", {30'd0, bus.m_address}, 32'd0);
    check("rst_m_writedata", {16'd0, bus.m_writedata}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);

    // Basic service with mask set, zero wait states
    cpu_write(2'd2, 32'd1);
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    nint = 1'b0;
    tick(2);
    check("lat_rd_not_yet", {31'd0, bus.m_read_n}, 32'd1);
    tick();
    check("lat_rd_low", {31'd0, bus.m_read_n}, 32'd0);
    check("rd_addr", {30'd0, bus.m_address}, 32'd2);
    tick();
    check("wr_low", {31'd0, bus.m_write_n}, 32'd0);
    check("wr_data", {16'd0, bus.m_writedata}, 32'h0012);
    tick();
    check("wr_released", {31'd0, bus.m_write_n}, 32'd1);
    tick();
    check("irq_early", {31'd0, irq}, 32'd0);
    tick();
    check("irq_at_s5", {31'd0, irq}, 32'd1);
    cpu_read(2'd0, rdata);
    check("status_pend", rdata, 32'h3);
    cpu_read(2'd1, rdata);
    check("capture", rdata, 32'h0012);
    check("rd_count1", rd_cnt - rd_base, 32'd1);
    check("wr_count1", wr_cnt - wr_base, 32'd1);
    check("rd_addr_seen", {30'd0, last_rd_addr}, 32'd2);
    check("wr_data_seen", {16'd0, last_wr_data}, 32'h0012);
    nint = 1'b1;
    tick(3);
    cpu_write(2'd3, 32'd1);
    tick(2);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Mask off, then enable and clear
    cpu_write(2'd2, 32'd0);
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    nint = 1'b0;
    tick(8);
    check("masked_irq", {31'd0, irq}, 32'd0);
    cpu_read(2'd0, rdata);
    check("masked_status", rdata, 32'h3);
    cpu_write(2'd2, 32'd1);
    check("mask_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("mask_irq_on", {31'd0, irq}, 32'd1);

    // Level semantics: nint still low, no new service until pending is cleared
    tick(5);
    check("no_rd_before_clr", rd_cnt - rd_base, 32'd1);
    cpu_write(2'd3, 32'd1);
    check("clr_rd_not_yet", {31'd0, bus.m_read_n}, 32'd1);
    tick();
    check("clr_irq_off", {31'd0, irq}, 32'd0);
    check("clr_rd_start", {31'd0, bus.m_read_n}, 32'd0);
    tick(13);
    check("level_rd_count", rd_cnt - rd_base, 32'd2);
    check("level_wr_count", wr_cnt - wr_base, 32'd2);
    cpu_read(2'd0, rdata);
    check("level_status", rdata, 32'h3);

    // Overrun: second falling edge while pending
    nint = 1'b1;
    tick(4);
    nint = 1'b0;
    tick(4);
    cpu_read(2'd0, rdata);
    check("overrun_status", rdata, 32'hB);
    check("overrun_no_rd", rd_cnt - rd_base, 32'd2);
    nint = 1'b1;
    tick(3);
    cpu_write(2'd3, 32'd3);
    tick(2);
    cpu_read(2'd0, rdata);
    check("overrun_cleared", rdata, 32'h0);

    // Timeout with waitrequest held high for about 300 cycles
    rd_base = rd_cnt;
    bus.m_waitrequest = 1'b1;
    nint = 1'b0;
    tick(3);
    check("tmo_rd_low", {31'd0, bus.m_read_n}, 32'd0);
    nint = 1'b1;
    tick(250);
    check("tmo_rd_held", {31'd0, bus.m_read_n}, 32'd0);
    tick(10);
    check("tmo_rd_released", {31'd0, bus.m_read_n}, 32'd1);
    tick(40);
    check("tmo_no_retry", {31'd0, bus.m_read_n}, 32'd1);
    bus.m_waitrequest = 1'b0;
    cpu_read(2'd0, rdata);
    check("tmo_status", rdata, 32'h10);
    check("tmo_no_rd", rd_cnt - rd_base, 32'd0);
    cpu_write(2'd3, 32'd4);
    cpu_read(2'd0, rdata);
    check("tmo_cleared", rdata, 32'h0);

    // Reset while stalled in the ack write
    wr_base = wr_cnt;
    nint = 1'b0;
    tick(4);
    check("wr_pre_reset", {31'd0, bus.m_write_n}, 32'd0);
    bus.m_waitrequest = 1'b1;
    tick();
    check("wr_stalled", {31'd0, bus.m_write_n}, 32'd0);
    reset = 1'b1;
    tick();
    check("rst_wr_release", {31'd0, bus.m_write_n}, 32'd1);
    check("rst_rd_release", {31'd0, bus.m_read_n}, 32'd1);
    nint = 1'b1;
    bus.m_waitrequest = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    check("rst2_readdata", bus.readdata, 32'd0);
    check("rst2_no_ack", wr_cnt - wr_base, 32'd0);
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), rdata);
      check($sformatf("rst2_reg%0d", a), rdata, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
